// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the I/D cache memory arbiter.
// States, block geometry and the block-offset mask live here.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_FILL_I,
    S_FILL_D,
    S_DONE
  } arb_state_t;

  localparam int ADDR_W      = 16;
  localparam int BLOCK_WORDS = 8;
  localparam int MEM_LATENCY = 4;
  localparam logic [15:0] OFF_MASK = 16'hFFF0;

endpackage

// File: rtl/mem_arbiter_fill_counter.sv
// Word counter for block fills: clear, enable, terminal count.
// Used once for read issues and once for read returns.
module fill_counter #(
  parameter int W    = 4,
  parameter int TERM = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         tc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == W'(TERM));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates I-miss, D-miss and D write-through onto one memory port.
// Fills stream a full block; returns are routed to the granted cache.
import mem_arb_pkg::*;

module mem_arbiter #(
  parameter int ADDR_W      = mem_arb_pkg::ADDR_W,
  parameter int BLOCK_WORDS = mem_arb_pkg::BLOCK_WORDS,
  parameter int MEM_LATENCY = mem_arb_pkg::MEM_LATENCY
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_miss,
  input  logic [ADDR_W-1:0] i_miss_addr,
  input  logic              d_miss,
  input  logic [ADDR_W-1:0] d_miss_addr,
  input  logic              d_wr_req,
  input  logic [ADDR_W-1:0] d_wr_addr,
  input  logic [15:0]       d_wr_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              mem_enable,
  output logic              mem_wr,
  input  logic              mem_data_valid,
  input  logic [15:0]       mem_rdata,
  output logic [15:0]       fill_data,
  output logic [2:0]        fill_word,
  output logic              i_fill_we,
  output logic              d_fill_we,
  output logic              i_fill_done,
  output logic              d_fill_done,
  output logic              d_wr_ack,
  output logic              busy
);

  // fill_word is 3 bits wide, so the block geometry is fixed
  if (BLOCK_WORDS != 8) begin : g_bad_block
    $error("mem_arbiter: BLOCK_WORDS must be 8");
  end
  if (MEM_LATENCY < 1) begin : g_bad_latency
    $error("mem_arbiter: MEM_LATENCY must be at least 1");
  end

  localparam logic [3:0] CNT_LAST = 4'(BLOCK_WORDS - 1);

  arb_state_t        state;
  logic [ADDR_W-1:0] base;
  logic              fill_d;
  logic              in_fill;
  logic [3:0]        iss_cnt;
  logic [3:0]        rcv_cnt;
  logic              iss_tc;
  logic              rcv_tc;

  assign in_fill = (state == S_FILL_I) || (state == S_FILL_D);

  fill_counter #(.W(4), .TERM(BLOCK_WORDS)) u_issue (
    .clk   (clk),
    .rst   (rst),
    .clr   (!in_fill),
    .en    (in_fill && !iss_tc),
    .count (iss_cnt),
    .tc    (iss_tc)
  );

  fill_counter #(.W(4), .TERM(BLOCK_WORDS)) u_recv (
    .clk   (clk),
    .rst   (rst),
    .clr   (!in_fill),
    .en    (in_fill && mem_data_valid && !rcv_tc),
    .count (rcv_cnt),
    .tc    (rcv_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      base   <= '0;
      fill_d <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (d_wr_req) begin
            state <= S_WRITE;
          end else if (d_miss) begin
            state  <= S_FILL_D;
            base   <= d_miss_addr & ADDR_W'(OFF_MASK);
            fill_d <= 1'b1;
          end else if (i_miss) begin
            state  <= S_FILL_I;
            base   <= i_miss_addr & ADDR_W'(OFF_MASK);
            fill_d <= 1'b0;
          end
        end
        S_WRITE: state <= S_IDLE;
        S_FILL_I, S_FILL_D: begin
          if (mem_data_valid && rcv_cnt == CNT_LAST) begin
            state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_enable  = 1'b0;
    mem_wr      = 1'b0;
    fill_data   = '0;
    fill_word   = '0;
    i_fill_we   = 1'b0;
    d_fill_we   = 1'b0;
    i_fill_done = 1'b0;
    d_fill_done = 1'b0;
    d_wr_ack    = 1'b0;
    unique case (state)
      S_WRITE: begin
        mem_enable = 1'b1;
        mem_wr     = 1'b1;
        mem_addr   = d_wr_addr;
        mem_wdata  = d_wr_data;
        d_wr_ack   = 1'b1;
      end
      S_FILL_I, S_FILL_D: begin
        if (!iss_tc) begin
          mem_enable = 1'b1;
          mem_addr   = base + ADDR_W'({iss_cnt, 1'b0});
        end
        if (mem_data_valid && !rcv_tc) begin
          fill_data = mem_rdata;
          fill_word = rcv_cnt[2:0];
          i_fill_we = (state == S_FILL_I);
          d_fill_we = (state == S_FILL_D);
        end
      end
      S_DONE: begin
        i_fill_done = !fill_d;
        d_fill_done = fill_d;
      end
      default: ;
    endcase
  end

  assign busy = (state != S_IDLE);

endmodule
